// File: rtl/comparator_reg_if.sv
// Operand/result bundle for comparator_reg. The master side presents operands and
// consumes results; the slave side is the comparator itself.
interface comparator_reg_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [WIDTH-1:0] max_out;
    logic [WIDTH-1:0] min_out;

    modport master (
        output in_valid, a, b,
        input  out_valid, eq, gt, lt, max_out, min_out
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, eq, gt, lt, max_out, min_out
    );
endinterface

// File: rtl/comparator_reg.sv
// Magnitude comparator with a registered result stage: one compare per accepted
// input, results and out_valid appear one cycle after in_valid is sampled.
module comparator_reg #(
    parameter int unsigned WIDTH  = 4,
    parameter bit          SIGNED = 1'b0
) (
    input logic             clk,
    input logic             rst,
    comparator_reg_if.slave bus
);
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             eq_d;
    logic             gt_d;
    logic             lt_d;
    logic [WIDTH-1:0] max_d;
    logic [WIDTH-1:0] min_d;

    logic             out_valid_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_q;

    // Flip the sign bit in signed mode so one unsigned compare orders both modes.
    always_comb begin
        a_key = bus.a;
        b_key = bus.b;
        if (SIGNED) begin
            a_key[WIDTH-1] = ~bus.a[WIDTH-1];
            b_key[WIDTH-1] = ~bus.b[WIDTH-1];
        end
    end

    // Derive the one-hot flags and the ordered pair; ties keep a as max, b as min.
    always_comb begin
        eq_d = (bus.a == bus.b);
        gt_d = (a_key > b_key);
        lt_d = ~eq_d & ~gt_d;
        if (lt_d) begin
            max_d = bus.b;
            min_d = bus.a;
        end else begin
            max_d = bus.a;
            min_d = bus.b;
        end
    end

    // out_valid follows in_valid every edge; results only move on accepted inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                eq_q  <= eq_d;
                gt_q  <= gt_d;
                lt_q  <= lt_d;
                max_q <= max_d;
                min_q <= min_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.max_out   = max_q;
    assign bus.min_out   = min_q;
endmodule

// File: tb/tb_comparator_reg.sv
// Bench for comparator_reg: four instances (4/8 bit, unsigned/signed) driven with
// the same stimulus and compared each cycle against a value-based reference model.
module tb_comparator_reg;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    comparator_reg_if #(.WIDTH(4)) if_u4 ();
    comparator_reg_if #(.WIDTH(4)) if_s4 ();
    comparator_reg_if #(.WIDTH(8)) if_u8 ();
    comparator_reg_if #(.WIDTH(8)) if_s8 ();

    comparator_reg #(.WIDTH(4), .SIGNED(1'b0)) u_u4 (.clk(clk), .rst(rst), .bus(if_u4));
    comparator_reg #(.WIDTH(4), .SIGNED(1'b1)) u_s4 (.clk(clk), .rst(rst), .bus(if_s4));
    comparator_reg #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (.clk(clk), .rst(rst), .bus(if_u8));
    comparator_reg #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (.clk(clk), .rst(rst), .bus(if_s8));

    // Outputs gathered into arrays, zero-extended to 8 bits.
    logic       o_valid [4];
    logic       o_eq    [4];
    logic       o_gt    [4];
    logic       o_lt    [4];
    logic [7:0] o_max   [4];
    logic [7:0] o_min   [4];

    assign o_valid[0] = if_u4.out_valid;
    assign o_valid[1] = if_s4.out_valid;
    assign o_valid[2] = if_u8.out_valid;
    assign o_valid[3] = if_s8.out_valid;
    assign o_eq[0]    = if_u4.eq;
    assign o_eq[1]    = if_s4.eq;
    assign o_eq[2]    = if_u8.eq;
    assign o_eq[3]    = if_s8.eq;
    assign o_gt[0]    = if_u4.gt;
    assign o_gt[1]    = if_s4.gt;
    assign o_gt[2]    = if_u8.gt;
    assign o_gt[3]    = if_s8.gt;
    assign o_lt[0]    = if_u4.lt;
    assign o_lt[1]    = if_s4.lt;
    assign o_lt[2]    = if_u8.lt;
    assign o_lt[3]    = if_s8.lt;
    assign o_max[0]   = {4'b0, if_u4.max_out};
    assign o_max[1]   = {4'b0, if_s4.max_out};
    assign o_max[2]   = if_u8.max_out;
    assign o_max[3]   = if_s8.max_out;
    assign o_min[0]   = {4'b0, if_u4.min_out};
    assign o_min[1]   = {4'b0, if_s4.min_out};
    assign o_min[2]   = if_u8.min_out;
    assign o_min[3]   = if_s8.min_out;

    // Reference model state: what each instance should show after the last edge.
    int unsigned cfg_w   [4] = '{4, 4, 8, 8};
    bit          cfg_s   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    string       cfg_n   [4] = '{"u4", "s4", "u8", "s8"};
    logic        m_valid [4];
    logic        m_eq    [4];
    logic        m_gt    [4];
    logic        m_lt    [4];
    logic [7:0]  m_max   [4];
    logic [7:0]  m_min   [4];
    bit          m_seen  [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Numeric value of the low w bits of x, as unsigned or two's complement.
    function automatic longint num(input int unsigned w, input bit sgn, input logic [7:0] x);
        longint v = 0;
        for (int i = 0; i < int'(w); i++) begin
            if (x[i]) v += longint'(1) << i;
        end
        if (sgn && x[w-1]) v -= longint'(1) << w;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 1'b0;
            m_eq[k]    = 1'b0;
            m_gt[k]    = 1'b0;
            m_lt[k]    = 1'b0;
            m_max[k]   = 8'h00;
            m_min[k]   = 8'h00;
            m_seen[k]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] msk;
            logic [7:0] am;
            logic [7:0] bm;
            longint     va;
            longint     vb;
            msk = (cfg_w[k] == 8) ? 8'hFF : 8'h0F;
            am  = a & msk;
            bm  = b & msk;
            m_valid[k] = v;
            if (v) begin
                va        = num(cfg_w[k], cfg_s[k], am);
                vb        = num(cfg_w[k], cfg_s[k], bm);
                m_eq[k]   = (va == vb);
                m_gt[k]   = (va > vb);
                m_lt[k]   = (va < vb);
                m_max[k]  = (va >= vb) ? am : bm;
                m_min[k]  = (va >= vb) ? bm : am;
                m_seen[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            check({cfg_n[k], ".out_valid"}, 64'(o_valid[k]), 64'(m_valid[k]));
            check({cfg_n[k], ".eq"},        64'(o_eq[k]),    64'(m_eq[k]));
            check({cfg_n[k], ".gt"},        64'(o_gt[k]),    64'(m_gt[k]));
            check({cfg_n[k], ".lt"},        64'(o_lt[k]),    64'(m_lt[k]));
            check({cfg_n[k], ".max_out"},   64'(o_max[k]),   64'(m_max[k]));
            check({cfg_n[k], ".min_out"},   64'(o_min[k]),   64'(m_min[k]));
            check({cfg_n[k], ".onehot"},
                  64'(o_eq[k]) + 64'(o_gt[k]) + 64'(o_lt[k]), m_seen[k] ? 64'd1 : 64'd0);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        if_u4.in_valid = v;
        if_u4.a        = a[3:0];
        if_u4.b        = b[3:0];
        if_s4.in_valid = v;
        if_s4.a        = a[3:0];
        if_s4.b        = b[3:0];
        if_u8.in_valid = v;
        if_u8.a        = a;
        if_u8.b        = b;
        if_s8.in_valid = v;
        if_s8.a        = a;
        if_s8.b        = b;
    endtask

    // Drive at a falling edge, let one rising edge pass, check at the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b);
        drive(v, a, b);
        model_step(v, a, b);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rv;

        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Directed sample points against fixed expectations.
        cycle(1'b1, 8'd9, 8'd3);
        check("dir_9_3.gt", 64'(if_u4.gt), 64'd1);
        check("dir_9_3.max", 64'(if_u4.max_out), 64'd9);
        check("dir_9_3.min", 64'(if_u4.min_out), 64'd3);
        cycle(1'b1, 8'd5, 8'd5);
        check("dir_5_5.eq", 64'(if_u4.eq), 64'd1);
        cycle(1'b1, 8'h08, 8'h07);
        check("dir_s_m8_7.lt", 64'(if_s4.lt), 64'd1);
        check("dir_s_m8_7.max", 64'(if_s4.max_out), 64'd7);
        check("dir_u_8_7.gt", 64'(if_u4.gt), 64'd1);
        cycle(1'b1, 8'h0F, 8'h00);
        check("dir_s_m1_0.lt", 64'(if_s4.lt), 64'd1);
        check("dir_u_15_0.gt", 64'(if_u4.gt), 64'd1);
        cycle(1'b1, 8'h0E, 8'h0D);
        check("dir_s_e_d.gt", 64'(if_s4.gt), 64'd1);
        cycle(1'b1, 8'h80, 8'h7F);
        check("dir_s8_min.lt", 64'(if_s8.lt), 64'd1);
        check("dir_u8_80.gt", 64'(if_u8.gt), 64'd1);

        // Valid gating: in_valid 1,0,0,1 shows out_valid one cycle late, flags hold.
        cycle(1'b1, 8'd2, 8'd7);
        check("gate.v1", 64'(if_u4.out_valid), 64'd1);
        check("gate.lt", 64'(if_u4.lt), 64'd1);
        cycle(1'b0, 8'd7, 8'd2);
        check("gate.idle_v", 64'(if_u4.out_valid), 64'd0);
        check("gate.idle_lt", 64'(if_u4.lt), 64'd1);
        cycle(1'b0, 8'd7, 8'd2);
        check("gate.idle_lt2", 64'(if_u4.lt), 64'd1);
        cycle(1'b1, 8'd7, 8'd2);
        check("gate.gt", 64'(if_u4.gt), 64'd1);

        // Asynchronous reset between edges, held across an edge with in_valid high.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        drive(1'b1, 8'd9, 8'd3);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        cycle(1'b1, 8'd9, 8'd3);

        // Exhaustive 4-bit sweep, back to back.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 8'(i >> 4), 8'(i & 15));
        end
        cycle(1'b0, 8'h00, 8'h00);

        // Randomised traffic with a bias toward extreme and equal operands.
        for (int i = 0; i < 1000; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = 8'h80;
                2: rb = 8'hFF;
                3: ra = 8'h7F;
                default: ;
            endcase
            cycle(rv, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
